mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Y86 memory stage that sits after the execute/memory pipeline register and consumes its outputs. It decodes the M-stage instruction, runs data-memory reads and writes over a req/ack handshake to a multi-cycle data memory, and stalls the pipeline while an access is outstanding. It also drives the memory/write-back pipeline register.

## Interface
Parameters:
- `RNONE`, 8'h0F: register ID meaning "no destination".
- `DMEM_TIMEOUT`, 16: number of REQ cycles without ack before the access is flagged as an ADR error.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset. Asynchronous, active-high.
- `mem_icode` in 8: M-stage icode.
- `mem_valA`, `mem_valP`, `mem_valE` in 32 each: M-stage operands.
- `mem_dstE`, `mem_dstM` in 8 each: M-stage destinations.
- `M_Cnd_i` in 1: condition flag. Passed through to W.
- `dmem_req` out 1: request valid.
- `dmem_we` out 1: write enable.
- `dmem_addr` out 32: byte address.
- `dmem_wdata` out 32: write data.
- `dmem_rdata` in 32: read data.
- `dmem_ack` in 1: access complete.
- `m_stall_o` out 1: freeze F/D/E/M.
- `wb_icode`, `wb_dstE`, `wb_dstM` out 8 each.
- `wb_valE`, `wb_valM` out 32 each.
- `wb_stat` out 3: 1=AOK, 2=HLT, 3=ADR, 4=INS.
- `W_Cnd_o` out 1.

## Operation
Decode:
- Read ops: MRMOVL (5), POPL (B), RET (9).
- Write ops: RMMOVL (4), PUSHL (A), CALL (8).
- Address: `mem_valA` for POPL and RET; `mem_valE` for the other memory ops.
- Write data: `mem_valP` for CALL; `mem_valA` otherwise.
- Any icode > 0xB gives status INS. HALT (0) gives HLT. Everything else gives AOK unless an error is raised.

FSM states:
- IDLE: memory op present → REQ, loading `dmem_addr`/`dmem_we`/`dmem_wdata`. Otherwise stay in IDLE.
- REQ: `dmem_req`=1, with addr/we/wdata held stable. On `dmem_ack` → DONE, capturing `dmem_rdata` into the internal valM for reads. After `DMEM_TIMEOUT` cycles without ack → DONE with an ADR error and `dmem_req` dropped.
- DONE: one cycle. The result is presented to the W register → IDLE.

`m_stall_o` = (IDLE and memory op present) or REQ. It is low in DONE and for non-memory ops.

W register update on every posedge:
- When `m_stall_o` is low: W loads icode, valE, valM (internal valM; 0 for non-reads), dstE, dstM, stat, Cnd.
- When `m_stall_o` is high: W loads a bubble: icode=1 (NOP), dstE=dstM=`RNONE`, stat=AOK, valE=valM=0, Cnd=0.

Errors and acks:
- On an ADR error, W receives stat=3, dstM=`RNONE`, and the original icode/dstE.
- An ack outside REQ is ignored.
- `dmem_req` never asserts for HLT, INS, or non-memory icodes.

## Timing
Reset (async): FSM=IDLE; `dmem_req`=0; `dmem_we`=0; addr and wdata 0; `m_stall_o`=0. W outputs take bubble values: icode 1, dstE/dstM 0x0F, valE/valM 0, stat 1, Cnd 0.

Latency:
- Non-memory op: W loads on the first edge.
- Memory op with ack in the first REQ cycle:
  - edge 1: IDLE→REQ
  - edge 2: REQ→DONE
  - edge 3: W loads, stall high for 2 cycles.
- Each extra cycle of ack delay adds one stall cycle.

Handshake:
- `dmem_req` is registered and stays high until the ack edge.
- The memory must not assume req is low in the cycle after ack.

Reset during REQ: req drops immediately, and any later ack is ignored.

A new M instruction arrives on the same edge DONE→IDLE and is evaluated in IDLE that cycle, so back-to-back memory ops incur no extra bubble.

## Configuration
`MEM_ALIGN_CHECK_EN`:
- Defined: a memory op whose address has `addr[1:0]`≠0 skips REQ and goes IDLE→DONE. `dmem_req` stays 0 and W gets stat=3 (ADR).
- Undefined: no alignment check; the full address is issued unchanged.

## Test plan
- Reset while in REQ with addr 0x100 → `dmem_req` low asynchronously; W bubble values (icode 1, dst 0x0F, stat 1); a following ack is ignored.
- MRMOVL, valE=0x40, dstM=3; ack with rdata 0xDEADBEEF in the first REQ cycle → `m_stall_o` high 2 cycles; W: icode 5, valM 0xDEADBEEF, dstM 3, stat 1.
- CALL, valE=0x1FC, valP=0x2A; ack delayed 3 cycles → req/we=1, addr 0x1FC, wdata 0x2A held 4 cycles; stall high 5 cycles; W bubbles until done.
- OPL then POPL (valA=0x80) back-to-back → OPL reaches W next edge with no stall; POPL issues a read at 0x80.
- RMMOVL, addr 0x42 → with `MEM_ALIGN_CHECK_EN`: no req, W stat 3. Without it: write to 0x42.
- MRMOVL with no ack for 16 REQ cycles → req drops; W stat 3, dstM 0x0F. Separately, icode 0xC → W stat 4 with no req.

Source files
------------

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - Y86 memory stage: decode, req/ack data-memory access, stall and M/W register.
// Optional alignment check: define MEM_ALIGN_CHECK_EN.
module mem_access_stage #(
  parameter logic [7:0] RNONE        = 8'h0F,
  parameter int         DMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  mem_icode,
  input  logic [31:0] mem_valA,
  input  logic [31:0] mem_valP,
  input  logic [31:0] mem_valE,
  input  logic [7:0]  mem_dstE,
  input  logic [7:0]  mem_dstM,
  input  logic        M_Cnd_i,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        m_stall_o,
  output logic [7:0]  wb_icode,
  output logic [7:0]  wb_dstE,
  output logic [7:0]  wb_dstM,
  output logic [31:0] wb_valE,
  output logic [31:0] wb_valM,
  output logic [2:0]  wb_stat,
  output logic        W_Cnd_o
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;
  localparam logic [15:0] TMO_LAST = 16'(DMEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        req_q, req_d, we_q, we_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, valm_q, valm_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  w_icode_q, w_icode_d, w_dste_q, w_dste_d, w_dstm_q, w_dstm_d;
  logic [31:0] w_vale_q, w_vale_d, w_valm_q, w_valm_d;
  logic [2:0]  w_stat_q, w_stat_d;
  logic        w_cnd_q, w_cnd_d;

  logic        is_rd, is_wr, is_mem, misalign, stall;
  logic [31:0] op_addr, op_wdata;

  always_comb begin
    is_rd    = (mem_icode == 8'h05) || (mem_icode == 8'h0B) || (mem_icode == 8'h09);
    is_wr    = (mem_icode == 8'h04) || (mem_icode == 8'h0A) || (mem_icode == 8'h08);
    is_mem   = is_rd || is_wr;
    op_addr  = ((mem_icode == 8'h0B) || (mem_icode == 8'h09)) ? mem_valA : mem_valE;
    op_wdata = (mem_icode == 8'h08) ? mem_valP : mem_valA;
`ifdef MEM_ALIGN_CHECK_EN
    misalign = (op_addr[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
    stall    = ((state_q == S_IDLE) && is_mem) || (state_q == S_REQ);
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    valm_d  = valm_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (is_mem) begin
          valm_d = 32'd0;
          cnt_d  = 16'd0;
          if (misalign) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_REQ;
            err_d   = 1'b0;
            req_d   = 1'b1;
            we_d    = is_wr;
            addr_d  = op_addr;
            wdata_d = op_wdata;
          end
        end
      end
      S_REQ: begin
        if (dmem_ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (!we_q) valm_d = dmem_rdata;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // While stalled W takes a bubble; in DONE the frozen M instruction retires with the access result.
  always_comb begin
    w_icode_d = 8'h01;
    w_dste_d  = RNONE;
    w_dstm_d  = RNONE;
    w_vale_d  = 32'd0;
    w_valm_d  = 32'd0;
    w_stat_d  = STAT_AOK;
    w_cnd_d   = 1'b0;
    if (!stall) begin
      w_icode_d = mem_icode;
      w_dste_d  = mem_dstE;
      w_vale_d  = mem_valE;
      w_cnd_d   = M_Cnd_i;
      if (state_q == S_DONE) begin
        w_valm_d = (is_rd && !err_q) ? valm_q : 32'd0;
        w_stat_d = err_q ? STAT_ADR : STAT_AOK;
        w_dstm_d = err_q ? RNONE : mem_dstM;
      end else begin
        w_dstm_d = mem_dstM;
        if (mem_icode == 8'h00)     w_stat_d = STAT_HLT;
        else if (mem_icode > 8'h0B) w_stat_d = STAT_INS;
        else                        w_stat_d = STAT_AOK;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      valm_q    <= 32'd0;
      err_q     <= 1'b0;
      cnt_q     <= 16'd0;
      w_icode_q <= 8'h01;
      w_dste_q  <= RNONE;
      w_dstm_q  <= RNONE;
      w_vale_q  <= 32'd0;
      w_valm_q  <= 32'd0;
      w_stat_q  <= STAT_AOK;
      w_cnd_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      valm_q    <= valm_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      w_icode_q <= w_icode_d;
      w_dste_q  <= w_dste_d;
      w_dstm_q  <= w_dstm_d;
      w_vale_q  <= w_vale_d;
      w_valm_q  <= w_valm_d;
      w_stat_q  <= w_stat_d;
      w_cnd_q   <= w_cnd_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign m_stall_o  = stall;
  assign wb_icode   = w_icode_q;
  assign wb_dstE    = w_dste_q;
  assign wb_dstM    = w_dstm_q;
  assign wb_valE    = w_vale_q;
  assign wb_valM    = w_valm_q;
  assign wb_stat    = w_stat_q;
  assign W_Cnd_o    = w_cnd_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage with a behavioural memory/stage model.
module tb_mem_access_stage;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  mem_icode = 8'h01;
  logic [31:0] mem_valA = 0, mem_valP = 0, mem_valE = 0;
  logic [7:0]  mem_dstE = 8'h0F, mem_dstM = 8'h0F;
  logic        M_Cnd_i = 1'b0;
  logic        dmem_req, dmem_we, dmem_ack, m_stall_o, W_Cnd_o;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, wb_valE, wb_valM;
  logic [7:0]  wb_icode, wb_dstE, wb_dstM;
  logic [2:0]  wb_stat;

  mem_access_stage dut (
    .clk(clk), .rst(rst), .mem_icode(mem_icode), .mem_valA(mem_valA), .mem_valP(mem_valP),
    .mem_valE(mem_valE), .mem_dstE(mem_dstE), .mem_dstM(mem_dstM), .M_Cnd_i(M_Cnd_i),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .m_stall_o(m_stall_o), .wb_icode(wb_icode),
    .wb_dstE(wb_dstE), .wb_dstM(wb_dstM), .wb_valE(wb_valE), .wb_valM(wb_valM),
    .wb_stat(wb_stat), .W_Cnd_o(W_Cnd_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  icode, dste, dstm;
    logic [31:0] vale, valm;
    logic [2:0]  stat;
    logic        cnd;
    int          stalls;
  } wexp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata;
    int          dly;
  } bexp_t;

  wexp_t exp_q[$];
  bexp_t bus_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  bit    mon_en = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  function automatic logic [31:0] rfun(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic chk_bubble(input string nm);
    chk({nm, "_ctl"}, {wb_icode, wb_dstE, wb_dstM, 4'b0, W_Cnd_o, wb_stat},
        {8'h01, 8'h0F, 8'h0F, 4'b0, 1'b0, 3'd1});
    chk({nm, "_val"}, wb_valE | wb_valM, 32'd0);
  endtask

  // Memory responder: acks after the scheduled delay, throws stray acks when idle.
  bexp_t cur;
  bit    busy = 0;
  int    rcnt = 0;
  initial begin
    dmem_ack = 0;
    dmem_rdata = 0;
    forever begin
      @(negedge clk);
      dmem_ack = 0;
      if (rst) begin
        busy = 0;
      end else if (dmem_req) begin
        if (!busy) begin
          busy = 1;
          rcnt = 0;
          if (bus_q.size() == 0) begin
            chk("unexpected_req", 32'd1, 32'd0);
            cur = '{we: dmem_we, addr: dmem_addr, wdata: dmem_wdata, dly: 0};
          end else begin
            cur = bus_q.pop_front();
          end
        end
        chk("bus_we", {31'd0, dmem_we}, {31'd0, cur.we});
        chk("bus_addr", dmem_addr, cur.addr);
        if (cur.we) chk("bus_wdata", dmem_wdata, cur.wdata);
        if (rcnt == cur.dly) begin
          dmem_ack = 1;
          dmem_rdata = rfun(cur.addr);
        end
        rcnt++;
      end else begin
        if (busy) chk("req_len", rcnt, (cur.dly < TMO) ? cur.dly + 1 : TMO);
        busy = 0;
        if ($urandom_range(0, 3) == 0) begin
          dmem_ack = 1;
          dmem_rdata = $urandom;
        end
      end
    end
  end

  // Monitor: a W load happens on every edge where stall was low.
  initial begin
    bit    have_prev;
    bit    stall_prev;
    int    stall_run;
    wexp_t e;
    have_prev = 0;
    stall_prev = 0;
    stall_run = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || rst) begin
        have_prev = 0;
        stall_run = 0;
      end else begin
        if (have_prev) begin
          if (!stall_prev) begin
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("w_icode", {24'd0, wb_icode}, {24'd0, e.icode});
              chk("w_dstE", {24'd0, wb_dstE}, {24'd0, e.dste});
              chk("w_dstM", {24'd0, wb_dstM}, {24'd0, e.dstm});
              chk("w_valE", wb_valE, e.vale);
              chk("w_valM", wb_valM, e.valm);
              chk("w_stat", {29'd0, wb_stat}, {29'd0, e.stat});
              chk("w_cnd", {31'd0, W_Cnd_o}, {31'd0, e.cnd});
              chk("stall_cycles", stall_run, e.stalls);
            end
            stall_run = 0;
          end else begin
            chk_bubble("w_bubble");
          end
        end
        stall_prev = m_stall_o;
        if (m_stall_o) stall_run++;
        have_prev = 1;
      end
    end
  end

  task automatic issue(input logic [7:0] ic, input logic [31:0] va, input logic [31:0] vp,
                       input logic [31:0] ve, input logic [7:0] de, input logic [7:0] dm,
                       input logic cnd, input int dly);
    wexp_t       e;
    bexp_t       b;
    bit          rd, wr, mis;
    logic [31:0] a;
    int          n;
    rd = (ic == 8'h05) || (ic == 8'h0B) || (ic == 8'h09);
    wr = (ic == 8'h04) || (ic == 8'h0A) || (ic == 8'h08);
    a  = ((ic == 8'h0B) || (ic == 8'h09)) ? va : ve;
    mis = 0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (a % 4) != 0;
`endif
    e = '{icode: ic, dste: de, dstm: dm, vale: ve, valm: 0, stat: 3'd1, cnd: cnd, stalls: 0};
    if (!(rd || wr)) begin
      if (ic == 8'h00) e.stat = 3'd2;
      else if (ic > 8'h0B) e.stat = 3'd4;
    end else if (mis) begin
      e.stat = 3'd3; e.dstm = 8'h0F; e.stalls = 1;
    end else begin
      b = '{we: wr, addr: a, wdata: (ic == 8'h08) ? vp : va, dly: dly};
      bus_q.push_back(b);
      if (dly >= TMO) begin
        e.stat = 3'd3; e.dstm = 8'h0F; e.stalls = TMO + 1;
      end else begin
        e.stalls = dly + 2;
        if (rd) e.valm = rfun(a);
      end
    end
    exp_q.push_back(e);
    mem_icode = ic; mem_valA = va; mem_valP = vp; mem_valE = ve;
    mem_dstE = de; mem_dstM = dm; M_Cnd_i = cnd;
    n = 0;
    forever begin
      @(negedge clk);
      if (!m_stall_o) break;
      n++;
      if (n > 100) begin
        chk("stall_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0]  ic;
    logic [31:0] va, ve;
    int          dly;
    repeat (2) @(negedge clk);
    chk_bubble("reset_w");
    chk("reset_req", {31'd0, dmem_req}, 32'd0);
    chk("reset_stall", {31'd0, m_stall_o}, 32'd0);
    rst = 0;
    @(posedge clk); #1;
    // Reset asserted while a read to 0x100 is outstanding.
    bus_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'd0, dly: 255});
    mem_icode = 8'h05; mem_valE = 32'h100; mem_dstM = 8'h03;
    n = 0;
    while (!dmem_req && n < 10) begin @(negedge clk); n++; end
    chk("rst_req_seen", {31'd0, dmem_req}, 32'd1);
    #2 rst = 1;
    #1 chk("rst_req_drop", {31'd0, dmem_req}, 32'd0);
    chk_bubble("rst_w");
    mem_icode = 8'h01; mem_dstM = 8'h0F; mem_valE = 0;
    bus_q.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_req", {31'd0, dmem_req}, 32'd0);
      chk("post_rst_stall", {31'd0, m_stall_o}, 32'd0);
    end
    @(posedge clk); #1;
    mon_en = 1;
    issue(8'h05, 32'h0, 32'h0, 32'h40, 8'h0F, 8'h03, 1'b0, 0);
    issue(8'h08, 32'h11, 32'h2A, 32'h1FC, 8'h04, 8'h0F, 1'b0, 3);
    issue(8'h06, 32'h5, 32'h0, 32'h77, 8'h02, 8'h0F, 1'b1, 0);
    issue(8'h0B, 32'h80, 32'h0, 32'h84, 8'h04, 8'h06, 1'b0, 1);
    issue(8'h04, 32'h1234, 32'h0, 32'h42, 8'h0F, 8'h0F, 1'b0, 0);
    issue(8'h05, 32'h0, 32'h0, 32'h200, 8'h0F, 8'h01, 1'b0, 255);
    issue(8'h0C, 32'h0, 32'h0, 32'h9, 8'h01, 8'h02, 1'b1, 0);
    issue(8'h00, 32'h0, 32'h0, 32'h0, 8'h0F, 8'h0F, 1'b0, 0);
    issue(8'h09, 32'h300, 32'h0, 32'h304, 8'h04, 8'h0F, 1'b1, 2);
    for (int i = 0; i < 250; i++) begin
      ic = 8'($urandom_range(0, 14));
      va = $urandom;
      ve = $urandom;
      if ($urandom_range(0, 7) != 0) begin va[1:0] = 2'b00; ve[1:0] = 2'b00; end
      dly = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 4);
      issue(ic, va, $urandom, ve, 8'($urandom), 8'($urandom), 1'($urandom), dly);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("drain", exp_q.size(), 32'd0);
    chk("bus_drain", bus_q.size(), 32'd0);
    mon_en = 0;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
